// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor: bit-serial a-b-bin, LSB first, one bit per clock; SERIAL_SUB_SAT_EN clamps underflow to zero
module serial_borrow_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic br;
  logic [CW-1:0] cnt;
  logic last, d_bit;
  assign last  = cnt == CW'(WIDTH - 1);
  assign d_bit = a_q[0] ^ b_q[0] ^ br;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and handshake outputs, decoded from state only
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: if (last) state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // operand capture on accept, then one bit of the borrow recurrence per cycle; cnt parks at WIDTH-1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
      br  <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
      d_q <= {d_bit, d_q[WIDTH-1:1]};
      br  <= (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br);
      if (!last) cnt <= cnt + CW'(1);
    end
  assign bout = br;
`ifdef SERIAL_SUB_SAT_EN
  assign diff = (state == DONE && br) ? '0 : d_q;
`else
  assign diff = d_q;
`endif
endmodule
